// File: rtl/rep_code_pkg.sv
// Shared constants and types for the repetition-code link (encoder and decoder).
// Contents: default word width / repetition factor, FSM state enum,
// counter-width helper.
package rep_code_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;
    localparam int unsigned REP_DEFAULT    = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rep_chip_counter.sv
// Chip/bit position counter for the repetition encoder.
// Ports:
//   clk, rst     clock, async active-high reset
//   load_i       restart at bit 0, chip 0 (new word); wins over en_i
//   en_i         advance one chip
//   rep_term_c   current chip is the last repetition of its bit
//   first_c      position is bit 0, chip 0
//   last_c       position is the final chip of the word
module rep_chip_counter
    import rep_code_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned REP    = REP_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic rep_term_c,
    output logic first_c,
    output logic last_c
);

    localparam int unsigned BIT_W = cnt_w(DATA_W);
    localparam int unsigned REP_W = cnt_w(REP);

    logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
    logic [REP_W-1:0] rep_idx_q, rep_idx_d;
    logic             bit_term;

    assign rep_term_c = (rep_idx_q == REP_W'(REP - 1));
    assign bit_term   = (bit_idx_q == BIT_W'(DATA_W - 1));
    assign first_c    = (bit_idx_q == '0) && (rep_idx_q == '0);
    assign last_c     = bit_term && rep_term_c;

    // Next position; after the final chip both counters return to zero.
    always_comb begin
        bit_idx_d = bit_idx_q;
        rep_idx_d = rep_idx_q;
        if (load_i) begin
            bit_idx_d = '0;
            rep_idx_d = '0;
        end else if (en_i) begin
            if (rep_term_c) begin
                rep_idx_d = '0;
                bit_idx_d = bit_term ? '0 : bit_idx_q + BIT_W'(1);
            end else begin
                rep_idx_d = rep_idx_q + REP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx_q <= '0;
            rep_idx_q <= '0;
        end else begin
            bit_idx_q <= bit_idx_d;
            rep_idx_q <= rep_idx_d;
        end
    end

endmodule

// File: rtl/rep_encoder_tx.sv
// Repetition-code serial transmitter: accepts a parallel word, emits each bit
// LSB-first repeated REP times as a valid/ready chip stream.
// Ports:
//   clk, rst            clock, async active-high reset
//   in_data/valid/ready word input handshake (in_ready depends on tx_ready)
//   tx_chip/valid/ready chip output handshake
//   tx_first, tx_last   markers for the first and final chip of a word
//   busy                a word is loaded and not fully sent
module rep_encoder_tx
    import rep_code_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned REP    = REP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_chip,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_first,
    output logic              tx_last,
    output logic              busy
);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              chip_acc;
    logic              word_acc;
    logic              rep_term;
    logic              pos_first;
    logic              pos_last;

    rep_chip_counter #(
        .DATA_W (DATA_W),
        .REP    (REP)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (word_acc),
        .en_i       (chip_acc && !word_acc),
        .rep_term_c (rep_term),
        .first_c    (pos_first),
        .last_c     (pos_last)
    );

    assign tx_valid = (state_q == SEND);
    assign busy     = (state_q == SEND);
    assign tx_chip  = shreg_q[0];
    assign tx_first = tx_valid && pos_first;
    assign tx_last  = tx_valid && pos_last;
    assign chip_acc = tx_valid && tx_ready;
    // Accepting on the final chip lets consecutive words run without a bubble.
    assign in_ready = (state_q == IDLE) || (chip_acc && tx_last);
    assign word_acc = in_valid && in_ready;

    // Next state and shift register.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: begin
                if (word_acc) begin
                    state_d = SEND;
                    shreg_d = in_data;
                end
            end
            SEND: begin
                if (word_acc) begin
                    shreg_d = in_data;
                end else if (chip_acc) begin
                    if (rep_term) begin
                        shreg_d = shreg_q >> 1;
                    end
                    if (tx_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: tb/tb_rep_encoder_tx.sv
// Testbench for rep_encoder_tx: queue-based chip-stream model checked every
// cycle, plus literal chip patterns for each directed scenario.
module tb_rep_encoder_tx;

    localparam int unsigned DW = 8;
    localparam int unsigned RP = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          tx_ready = 1'b0;
    logic          in_ready, tx_chip, tx_valid, tx_first, tx_last, busy;

    logic [0:0]    in_data2 = '0;
    logic          in_valid2 = 1'b0;
    logic          tx_ready2 = 1'b1;
    logic          in_ready2, tx_chip2, tx_valid2, tx_first2, tx_last2, busy2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rep_encoder_tx #(.DATA_W(DW), .REP(RP)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .tx_chip(tx_chip), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_first(tx_first), .tx_last(tx_last), .busy(busy)
    );

    rep_encoder_tx #(.DATA_W(1), .REP(5)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .tx_chip(tx_chip2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .tx_first(tx_first2), .tx_last(tx_last2), .busy(busy2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: queue of chips still to send ----------------
    typedef struct packed {
        logic chip;
        logic first;
        logic last;
    } chip_t;

    chip_t mq[$];

    function automatic logic m_in_ready();
        return (mq.size() == 0) || (mq.size() == 1 && tx_ready);
    endfunction

    always @(posedge clk or posedge rst) begin : model
        logic take;
        chip_t c;
        if (rst) begin
            mq.delete();
        end else begin
            take = in_valid && m_in_ready();
            if (mq.size() > 0 && tx_ready) void'(mq.pop_front());
            if (take) begin
                for (int b = 0; b < int'(DW); b++) begin
                    for (int r = 0; r < int'(RP); r++) begin
                        c.chip  = in_data[b];
                        c.first = (b == 0) && (r == 0);
                        c.last  = (b == int'(DW) - 1) && (r == int'(RP) - 1);
                        mq.push_back(c);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", in_ready, m_in_ready());
            chk("tx_valid", tx_valid, mq.size() != 0);
            chk("busy", busy, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("tx_chip", tx_chip, mq[0].chip);
                chk("tx_first", tx_first, mq[0].first);
                chk("tx_last", tx_last, mq[0].last);
            end else begin
                chk("idle_chip", tx_chip, 1'b0);
                chk("idle_first", tx_first, 1'b0);
                chk("idle_last", tx_last, 1'b0);
            end
        end
    end

    // ---------------- record of accepted chips ----------------
    bit col_chip  [0:1023];
    bit col_first [0:1023];
    bit col_last  [0:1023];
    bit col_inr   [0:1023];
    int col_cyc   [0:1023];
    int col_n = 0;
    int cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && tx_valid && tx_ready && col_n < 1024) begin
            col_chip[col_n]  <= tx_chip;
            col_first[col_n] <= tx_first;
            col_last[col_n]  <= tx_last;
            col_inr[col_n]   <= in_ready;
            col_cyc[col_n]   <= cyc;
            col_n            <= col_n + 1;
        end
    end

    task automatic chk_seq(input string name, input int base, input int n, input logic [47:0] exp);
        logic [47:0] got;
        got = '0;
        for (int i = 0; i < n; i++) got[i] = col_chip[base + i];
        chk(name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int   base;
    int   guard;
    logic [7:0] lf;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_chip", tx_chip, 1'b0);
        chk("rst_tx_first", tx_first, 1'b0);
        chk("rst_tx_last", tx_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dut2_valid", tx_valid2, 1'b0);
        chk("rst_dut2_ready", in_ready2, 1'b1);
        rst = 1'b0;
        step();

        // Single word 0xA5, no backpressure
        base = col_n;
        in_data = 8'hA5; in_valid = 1'b1; tx_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("model_len", mq.size(), 24);
        chk("model_head_first", mq[0].first, 1'b1);
        chk("model_tail_last", mq[23].last, 1'b1);
        repeat (26) step();
        chk("a5_count", col_n - base, 24);
        chk_seq("a5_chips", base, 24, 48'hE381C7);
        chk("a5_first0", col_first[base], 1'b1);
        chk("a5_last23", col_last[base + 23], 1'b1);
        chk("a5_ready23", col_inr[base + 23], 1'b1);
        chk("a5_ready22", col_inr[base + 22], 1'b0);

        // Back-to-back 0xFF then 0x00
        base = col_n;
        in_data = 8'hFF; in_valid = 1'b1;
        step();
        in_data = 8'h00;
        repeat (24) step();
        in_valid = 1'b0;
        repeat (26) step();
        chk("b2b_count", col_n - base, 48);
        chk_seq("b2b_chips", base, 48, 48'h000000FFFFFF);
        chk("b2b_nogap", col_cyc[base + 47] - col_cyc[base], 47);
        chk("b2b_first24", col_first[base + 24], 1'b1);

        // Backpressure with 0x3C
        base = col_n;
        tx_ready = 1'b0;
        in_data = 8'h3C; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lf = 8'hA7;
        guard = 0;
        while ((col_n - base) < 24 && guard < 400) begin
            lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
            tx_ready = lf[0];
            step();
            guard++;
        end
        tx_ready = 1'b1;
        repeat (3) step();
        chk("bp_count", col_n - base, 24);
        chk_seq("bp_chips", base, 24, 48'h03FFC0);
        chk("bp_first0", col_first[base], 1'b1);
        chk("bp_last23", col_last[base + 23], 1'b1);

        // 0x7E offered while 0x81 is mid-word
        base = col_n;
        in_data = 8'h81; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        in_data = 8'h7E; in_valid = 1'b1;
        repeat (19) step();
        in_valid = 1'b0;
        repeat (26) step();
        chk("mid_count", col_n - base, 48);
        chk_seq("mid_chips", base, 48, 48'h1FFFF8E00007);
        chk("mid_ready22", col_inr[base + 22], 1'b0);
        chk("mid_ready23", col_inr[base + 23], 1'b1);
        chk("mid_first24", col_first[base + 24], 1'b1);
        chk("mid_nogap", col_cyc[base + 24] - col_cyc[base + 23], 1);

        // Reset during chip 10 of 0xA5, then 0x5A
        base = col_n;
        in_data = 8'hA5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        #1;
        chk("mrst_tx_valid", tx_valid, 1'b0);
        chk("mrst_in_ready", in_ready, 1'b1);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_tx_chip", tx_chip, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mrst_partial", col_n - base, 10);
        step();
        chk("mrst_quiet", col_n - base, 10);
        base = col_n;
        in_data = 8'h5A; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (26) step();
        chk("5a_count", col_n - base, 24);
        chk_seq("5a_chips", base, 24, 48'h1C7E38);
        chk("5a_first0", col_first[base], 1'b1);

        // DATA_W=1, REP=5 instance
        in_data2 = 1'b1; in_valid2 = 1'b1;
        step();
        in_valid2 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("p_valid", tx_valid2, 1'b1);
            chk("p_chip", tx_chip2, 1'b1);
            chk("p_first", tx_first2, k == 0);
            chk("p_last", tx_last2, k == 4);
            chk("p_busy", busy2, 1'b1);
            step();
        end
        chk("p_done_valid", tx_valid2, 1'b0);
        chk("p_done_ready", in_ready2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rep_encoder_tx.md
# rep_encoder_tx

Serial repetition-code transmitter: the encoding end of the majority-vote link whose receiver recovers each data bit as the majority of REP repeated chips. It accepts parallel words over a valid/ready handshake. It emits each bit LSB-first, repeated REP times, as a chip stream with its own valid/ready handshake. It sits between the word source and the serial line driver; the maj-based decoder sits at the far end.

## Interface
- DATA_W, 8, data bits per word (≥1)
- REP, 3, chips per bit; odd, ≥3 (majority-decodable)
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_data  input  DATA_W  word to encode
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a word this cycle
- tx_chip  output  1  current chip value
- tx_valid  output  1  tx_chip valid
- tx_ready  input  1  downstream accepts chip this cycle
- tx_first  output  1  high with the first chip of a word
- tx_last  output  1  high with the final chip of a word
- busy  output  1  a word is loaded and not fully sent

## Operation
- Two states:
  - IDLE: no word loaded.
  - SEND: shift register holds the word; bit counter bit_idx is 0..DATA_W-1; chip counter rep_idx is 0..REP-1.
- Word accept:
  - Occurs when in_valid && in_ready. The word is loaded into the shift register, bit_idx=0, rep_idx=0, state→SEND.
  - in_ready = (state==IDLE) || (state==SEND && tx_valid && tx_ready && tx_last). This allows back-to-back words with no bubble.
- tx_chip = shreg[0]. tx_valid = (state==SEND).
- Chip accept (tx_valid && tx_ready):
  - If rep_idx<REP-1: rep_idx++.
  - Otherwise: rep_idx=0, shreg >>= 1, bit_idx++.
- tx_first = SEND && bit_idx==0 && rep_idx==0.
- tx_last = SEND && bit_idx==DATA_W-1 && rep_idx==REP-1.
- When the last chip is accepted:
  - If a new word is accepted in the same cycle: reload and stay in SEND.
  - Otherwise: go to IDLE.
- tx_ready low: all state holds; tx_chip, tx_first and tx_last remain stable (AXI-style, no retraction).
- in_data is sampled only on accept; changes at other times are ignored.
- busy = (state==SEND).
- Counter widths: $clog2(DATA_W) and $clog2(REP), minimum 1 bit. Neither counter ever exceeds its terminal value, so no wrap beyond range.

## Timing
- Reset values:
  - state=IDLE, shreg=0, counters=0.
  - Outputs: in_ready=1, tx_valid=0, tx_chip=0, tx_first=0, tx_last=0, busy=0.
- Latency: word accepted at edge N; first chip valid in the cycle after edge N.
- Throughput: one chip per cycle with tx_ready held high. A word takes DATA_W·REP cycles; consecutive words have zero gap.
- tx_valid, tx_chip and busy are registered state. in_ready, tx_first and tx_last are decoded from registers; in_ready also depends combinationally on tx_ready.
- Reset asserted mid-word: the word is discarded immediately (asynchronous). No partial chips are emitted after release; the next output is the first chip of a newly accepted word.
- in_valid asserted while in SEND and not on the last accepted chip: no accept. The source must hold the word.

## Structure
- Shared package rep_code_pkg holds:
  - the state enum (IDLE, SEND);
  - the default REP and DATA_W localparams;
  - a function for the counter width (max(1,$clog2(n))). The decoder side reuses the same constants.
- One sub-module, rep_chip_counter:
  - holds the rep_idx/bit_idx pair with enable, load and terminal-count flags;
  - is parameterized by DATA_W and REP.
- Top level holds the FSM, shift register and handshake logic.

## Test plan
- Reset, then in_data=0xA5 with tx_ready held high:
  - 24 chips, in bit order 1,0,1,0,0,1,0,1, each repeated 3 times;
  - tx_first on chip 0 and tx_last on chip 23;
  - in_ready high again on chip 23.
- Back-to-back words 0xFF then 0x00 with in_valid continuous: 48 consecutive valid chips (24 ones, then 24 zeros), no idle cycle between them.
- Backpressure: word 0x3C with tx_ready toggling pseudo-randomly. tx_chip, tx_first and tx_last must be stable while tx_valid && !tx_ready. The accepted chip sequence must equal the expected 24-chip pattern.
- in_valid asserted mid-word (0x81 sending, 0x7E offered at chip 5): in_ready stays low until chip 23 is accepted, then 0x7E is taken on that edge.
- Reset asserted at chip 10 of 0xA5: tx_valid=0 and in_ready=1 immediately. After release, 0x5A is sent in full from chip 0.
- Parameter sweep DATA_W=1, REP=5: word 1 gives exactly 5 one-chips, with tx_first and tx_last both asserted on chip 0 and chip 4 respectively.
